rrv2rvh_ruby_req_sched: RTL and testbench
=========================================

Name: rrv2rvh_ruby_req_sched

Overview:
- Issue scheduler between the Ruby random tester front-end and the rvh L1D load and store request ports.
- Accepts one already-translated Ruby request per cycle into a single-entry head register.
- Steers plain loads to the L1D load port, and plain stores to the store port.
- Serializes fences and atomics (LR/SC/AMO): waits until no requests are outstanding, issues the serializing request, then waits for its response before admitting new traffic.
- Tracks the outstanding-request count, bounded by MAX_OUTSTANDING.

Parameters:
- MAX_OUTSTANDING, 8: maximum requests issued to L1D without a response.
- ID_W, 8: Ruby transaction ID width.
- PADDR_W, 56: physical address width.
- XLEN, 64: store data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ruby_req_vld_i  in  1  Ruby request valid.
- ruby_req_rdy_o  out  1  request accepted this cycle when vld and rdy are both high.
- ruby_req_is_ld_i  in  1  1 = load-port request, 0 = store-port request.
- ruby_req_is_ser_i  in  1  serializing request (fence, LR, SC, AMO); always a store-port request.
- ruby_req_ld_type_i  in  ldu_minor_op_t  load minor op.
- ruby_req_st_type_i  in  stu_minor_op_t  store/atomic/fence minor op.
- ruby_req_id_i  in  ID_W  transaction ID.
- ruby_req_paddr_i  in  PADDR_W  address.
- ruby_req_data_i  in  XLEN  store data.
- ld_req_vld_o  out  1  L1D load request valid.
- ld_req_rdy_i  in  1  L1D load ready.
- ld_req_type_o  out  ldu_minor_op_t  load op.
- ld_req_id_o  out  ID_W  load ID.
- ld_req_paddr_o  out  PADDR_W  load address.
- st_req_vld_o  out  1  L1D store request valid.
- st_req_rdy_i  in  1  L1D store ready.
- st_req_type_o  out  stu_minor_op_t  store op.
- st_req_id_o  out  ID_W  store ID.
- st_req_paddr_o  out  PADDR_W  store address.
- st_req_data_o  out  XLEN  store data.
- ld_resp_vld_i  in  1  one load response completed.
- st_resp_vld_i  in  1  one store/atomic/fence response completed.
- outstanding_cnt_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count.
- busy_o  out  1  head valid, or count != 0, or state != RUN.
- err_o  out  1  sticky: a response arrived while the count was 0.

Behaviour:
- Reset (async, any state):
  - head invalid, state RUN, count 0, err_o 0.
  - All vld outputs 0, ruby_req_rdy_o 0 while rst is high.
  - Payload outputs reset to 0.
- Head register:
  - Captures all request fields on accept.
  - ld_* payload is driven from head when head is a load; st_* payload is driven when head is a store; the other port's payload is don't-care.
- States:
  - RUN:
    - Non-serializing head: raise the port vld (ld or st by is_ld) when count < MAX_OUTSTANDING.
    - Fire = vld & rdy. On fire, count += 1 and head clears unless refilled the same cycle.
    - Serializing head: no vld; next state DRAIN.
  - DRAIN:
    - st_req_vld_o = 1 only when count == 0.
    - On st fire: count += 1, head clears, next state SER_WAIT.
  - SER_WAIT:
    - No issue.
    - When count == 0 (sampled registered), next state RUN.
- ruby_req_rdy_o = state==RUN && (!head_vld || (head_fire && !head_ser)).
  - Back-to-back issue of one request per cycle is possible.
  - A serializing head blocks acceptance until RUN resumes; the earliest accept is the cycle after SER_WAIT exits.
- Latency: accepted at cycle N; earliest port vld at N+1.
- Valid stability: once raised, vld and payload hold until rdy; never retracted.
  - The count-limit gate is evaluated only when vld is not already asserted.
- Counter:
  - cnt_next = cnt + fire − ld_resp_vld_i − st_resp_vld_i.
  - Fire and up to two responses may occur in the same cycle; a net change of −2..+1 is legal.
  - Underflow (responses exceed cnt + fire): cnt saturates at 0 and err_o is set, held until rst.
  - At count == MAX_OUTSTANDING with a simultaneous response: the gate uses the registered count, so issue waits one cycle.
- ld_resp and st_resp are never back-pressured.

Test Plan:
- 3 loads IDs 1,2,3 back-to-back, ld_req_rdy_i=1 → ld_req_vld_o high cycles 1–3 with IDs 1,2,3; outstanding_cnt_o reaches 3; three ld_resp pulses → 0, busy_o low.
- MAX_OUTSTANDING=8: 10 stores, no responses → exactly 8 st fires and st_req_vld_o stays low; head holds ID 9 and ruby_req_rdy_o=0; one st_resp → ID 9 issues the cycle after the count drops.
- 2 loads outstanding, then fence ID 0x20 → DRAIN, no st_req_vld_o until both ld_resp arrive; fence issues with count 0; ruby_req_rdy_o stays 0 until its st_resp, then returns to RUN.
- AMOADDD followed by LD: st_req_rdy_i low 5 cycles → vld and payload stable throughout; the LD is not accepted until the AMO response returns.
- Same cycle: fire, ld_resp and st_resp at count 2 → count 1; st_resp at count 0 → count stays 0, err_o=1 and stays set.
- Assert rst mid-DRAIN with count 3 → immediately count 0, vld 0, state RUN, err_o 0.

Source files
------------

// File: rtl/rrv2rvh_ruby_req_sched_if.sv
// ============================================================================
//  Module      : rrv2rvh_ruby_req_sched_if
//  Description : Request/issue/response bundle between the Ruby tester
//                front-end, the request scheduler and the rvh L1D ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rrv2rvh_ruby_req_sched_if #(
    parameter int ID_W    = 8,
    parameter int PADDR_W = 56,
    parameter int XLEN    = 64,
    parameter int LDOP_W  = 4,
    parameter int STOP_W  = 5
) ();
    // Ruby front-end request
    logic               ruby_req_vld_i;
    logic               ruby_req_rdy_o;
    logic               ruby_req_is_ld_i;
    logic               ruby_req_is_ser_i;
    logic [LDOP_W-1:0]  ruby_req_ld_type_i;
    logic [STOP_W-1:0]  ruby_req_st_type_i;
    logic [ID_W-1:0]    ruby_req_id_i;
    logic [PADDR_W-1:0] ruby_req_paddr_i;
    logic [XLEN-1:0]    ruby_req_data_i;
    // L1D load port
    logic               ld_req_vld_o;
    logic               ld_req_rdy_i;
    logic [LDOP_W-1:0]  ld_req_type_o;
    logic [ID_W-1:0]    ld_req_id_o;
    logic [PADDR_W-1:0] ld_req_paddr_o;
    // L1D store port
    logic               st_req_vld_o;
    logic               st_req_rdy_i;
    logic [STOP_W-1:0]  st_req_type_o;
    logic [ID_W-1:0]    st_req_id_o;
    logic [PADDR_W-1:0] st_req_paddr_o;
    logic [XLEN-1:0]    st_req_data_o;
    // Completion pulses
    logic               ld_resp_vld_i;
    logic               st_resp_vld_i;

    // Environment side: drives requests, L1D readiness and responses
    modport master (
        output ruby_req_vld_i, ruby_req_is_ld_i, ruby_req_is_ser_i,
               ruby_req_ld_type_i, ruby_req_st_type_i, ruby_req_id_i,
               ruby_req_paddr_i, ruby_req_data_i,
               ld_req_rdy_i, st_req_rdy_i, ld_resp_vld_i, st_resp_vld_i,
        input  ruby_req_rdy_o,
               ld_req_vld_o, ld_req_type_o, ld_req_id_o, ld_req_paddr_o,
               st_req_vld_o, st_req_type_o, st_req_id_o, st_req_paddr_o,
               st_req_data_o
    );

    // Scheduler side
    modport slave (
        input  ruby_req_vld_i, ruby_req_is_ld_i, ruby_req_is_ser_i,
               ruby_req_ld_type_i, ruby_req_st_type_i, ruby_req_id_i,
               ruby_req_paddr_i, ruby_req_data_i,
               ld_req_rdy_i, st_req_rdy_i, ld_resp_vld_i, st_resp_vld_i,
        output ruby_req_rdy_o,
               ld_req_vld_o, ld_req_type_o, ld_req_id_o, ld_req_paddr_o,
               st_req_vld_o, st_req_type_o, st_req_id_o, st_req_paddr_o,
               st_req_data_o
    );
endinterface

`default_nettype wire

// File: rtl/rrv2rvh_ruby_req_sched.sv
// ============================================================================
//  Module      : rrv2rvh_ruby_req_sched
//  Description : Single-entry issue scheduler from the Ruby random tester to
//                the rvh L1D load/store ports. Serializes fences and atomics
//                and tracks the outstanding-request count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rrv2rvh_ruby_req_sched #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int ID_W            = 8,
    parameter int PADDR_W         = 56,
    parameter int XLEN            = 64,
    parameter int LDOP_W          = 4,
    parameter int STOP_W          = 5
) (
    input  wire logic                                clk,
    input  wire logic                                rst,
    rrv2rvh_ruby_req_sched_if.slave                  bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_cnt_o,
    output logic                                     busy_o,
    output logic                                     err_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] DRAIN    = 2'd1;
    localparam logic [1:0] SER_WAIT = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               underflow;
    logic               err;

    logic               head_vld;
    logic               head_is_ld;
    logic               head_ser;
    logic [LDOP_W-1:0]  head_ld_type;
    logic [STOP_W-1:0]  head_st_type;
    logic [ID_W-1:0]    head_id;
    logic [PADDR_W-1:0] head_paddr;
    logic [XLEN-1:0]    head_data;

    logic               ld_vld;
    logic               st_vld;
    logic               head_fire;
    logic               accept;
    logic               rdy;

    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W:0]     cnt_dec;
    logic [CNT_W:0]     cnt_diff;

    assign head_fire = (ld_vld & bus.ld_req_rdy_i) | (st_vld & bus.st_req_rdy_i);

    // Issue gating. vld can only drop through a fire: the count never grows
    // without a fire, so once the limit gate passes it stays passed.
    always_comb begin
        ld_vld = 1'b0;
        st_vld = 1'b0;
        case (state)
            RUN: begin
                if (head_vld && !head_ser && (cnt < CNT_MAX)) begin
                    ld_vld = head_is_ld;
                    st_vld = !head_is_ld;
                end
            end
            DRAIN: begin
                st_vld = head_vld && (cnt == '0);
            end
            default: begin
                ld_vld = 1'b0;
                st_vld = 1'b0;
            end
        endcase
    end

    // Accept when the head is empty or is being vacated by a plain request
    assign rdy    = !rst && (state == RUN) && (!head_vld || (head_fire && !head_ser));
    assign accept = bus.ruby_req_vld_i && rdy;

    // Head register capture / release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_vld     <= 1'b0;
            head_is_ld   <= 1'b0;
            head_ser     <= 1'b0;
            head_ld_type <= '0;
            head_st_type <= '0;
            head_id      <= '0;
            head_paddr   <= '0;
            head_data    <= '0;
        end else if (accept) begin
            head_vld     <= 1'b1;
            head_is_ld   <= bus.ruby_req_is_ld_i;
            head_ser     <= bus.ruby_req_is_ser_i;
            head_ld_type <= bus.ruby_req_ld_type_i;
            head_st_type <= bus.ruby_req_st_type_i;
            head_id      <= bus.ruby_req_id_i;
            head_paddr   <= bus.ruby_req_paddr_i;
            head_data    <= bus.ruby_req_data_i;
        end else if (head_fire) begin
            head_vld     <= 1'b0;
        end
    end

    // Serialization state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:      if (head_vld && head_ser)  state <= DRAIN;
                DRAIN:    if (st_vld && bus.st_req_rdy_i) state <= SER_WAIT;
                SER_WAIT: if (cnt == '0)             state <= RUN;
                default:                             state <= RUN;
            endcase
        end
    end

    // Next count: +fire, -each response, clamped at zero on underflow
    always_comb begin
        cnt_sum   = {1'b0, cnt} + {{CNT_W{1'b0}}, head_fire};
        cnt_dec   = {{CNT_W{1'b0}}, bus.ld_resp_vld_i} + {{CNT_W{1'b0}}, bus.st_resp_vld_i};
        cnt_diff  = cnt_sum - cnt_dec;
        underflow = 1'b0;
        cnt_next  = cnt_diff[CNT_W-1:0];
        if (cnt_dec > cnt_sum) begin
            underflow = 1'b1;
            cnt_next  = '0;
        end
    end

    // Outstanding counter and sticky underflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (underflow) err <= 1'b1;
        end
    end

    assign bus.ruby_req_rdy_o = rdy;
    assign bus.ld_req_vld_o   = ld_vld;
    assign bus.ld_req_type_o  = head_ld_type;
    assign bus.ld_req_id_o    = head_id;
    assign bus.ld_req_paddr_o = head_paddr;
    assign bus.st_req_vld_o   = st_vld;
    assign bus.st_req_type_o  = head_st_type;
    assign bus.st_req_id_o    = head_id;
    assign bus.st_req_paddr_o = head_paddr;
    assign bus.st_req_data_o  = head_data;

    assign outstanding_cnt_o = cnt;
    assign busy_o            = head_vld || (cnt != '0) || (state != RUN);
    assign err_o             = err;
endmodule

`default_nettype wire

// File: tb/tb_rrv2rvh_ruby_req_sched.sv
// ============================================================================
//  Module      : tb_rrv2rvh_ruby_req_sched
//  Description : Directed self-checking bench for rrv2rvh_ruby_req_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rrv2rvh_ruby_req_sched;
    localparam int MAX_OUTSTANDING = 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [3:0] LD_D    = 4'h3;
    localparam logic [4:0] ST_D    = 5'h03;
    localparam logic [4:0] AMOADDD = 5'h0A;
    localparam logic [4:0] FENCE   = 5'h1F;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    rrv2rvh_ruby_req_sched_if #(.ID_W(8), .PADDR_W(56), .XLEN(64), .LDOP_W(4), .STOP_W(5)) bus ();

    rrv2rvh_ruby_req_sched #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING), .ID_W(8), .PADDR_W(56), .XLEN(64),
        .LDOP_W(4), .STOP_W(5)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .outstanding_cnt_o(cnt), .busy_o(busy), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic is_ld, input logic ser, input logic [3:0] ldt,
                         input logic [4:0] stt, input logic [7:0] id,
                         input logic [55:0] pa, input logic [63:0] d);
        bus.ruby_req_vld_i     = 1'b1;
        bus.ruby_req_is_ld_i   = is_ld;
        bus.ruby_req_is_ser_i  = ser;
        bus.ruby_req_ld_type_i = ldt;
        bus.ruby_req_st_type_i = stt;
        bus.ruby_req_id_i      = id;
        bus.ruby_req_paddr_i   = pa;
        bus.ruby_req_data_i    = d;
    endtask

    task automatic idle();
        bus.ruby_req_vld_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_cnt", 64'(cnt), 0);
        check("rst_err", 64'(err), 0);
        check("rst_rdy", 64'(bus.ruby_req_rdy_o), 0);
        check("rst_ldvld", 64'(bus.ld_req_vld_o), 0);
        check("rst_stvld", 64'(bus.st_req_vld_o), 0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int fires;
        int id;
        logic acc;

        rst = 1'b0;
        bus.ruby_req_vld_i = 1'b0; bus.ruby_req_is_ld_i = 1'b0; bus.ruby_req_is_ser_i = 1'b0;
        bus.ruby_req_ld_type_i = '0; bus.ruby_req_st_type_i = '0; bus.ruby_req_id_i = '0;
        bus.ruby_req_paddr_i = '0; bus.ruby_req_data_i = '0;
        bus.ld_req_rdy_i = 1'b0; bus.st_req_rdy_i = 1'b0;
        bus.ld_resp_vld_i = 1'b0; bus.st_resp_vld_i = 1'b0;
        #2;
        do_reset();
        check("rst_busy", 64'(busy), 0);
        check("rst_st_paddr", 64'(bus.st_req_paddr_o), 0);

        // ---- Three back-to-back loads
        bus.ld_req_rdy_i = 1'b1; bus.st_req_rdy_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, LD_D, 5'h0, 8'(i), 56'h1000 + 56'(i), 64'h0);
            mid();
            check("t1_rdy", 64'(bus.ruby_req_rdy_o), 1);
            if (i > 1) begin
                check("t1_ldvld", 64'(bus.ld_req_vld_o), 1);
                check("t1_ldid", 64'(bus.ld_req_id_o), 64'(i - 1));
            end
            step();
        end
        idle();
        mid();
        check("t1_ldvld3", 64'(bus.ld_req_vld_o), 1);
        check("t1_ldid3", 64'(bus.ld_req_id_o), 3);
        check("t1_ldpa3", 64'(bus.ld_req_paddr_o), 64'h1003);
        step();
        mid();
        check("t1_ldvld_off", 64'(bus.ld_req_vld_o), 0);
        check("t1_cnt3", 64'(cnt), 3);
        bus.ld_resp_vld_i = 1'b1;
        step(); step(); step();
        bus.ld_resp_vld_i = 1'b0;
        mid();
        check("t1_cnt0", 64'(cnt), 0);
        check("t1_busy", 64'(busy), 0);

        // ---- Ten stores against the outstanding limit
        do_reset();
        fires = 0;
        id = 1;
        drive(1'b0, 1'b0, 4'h0, ST_D, 8'(id), 56'h2000, 64'h11);
        for (int c = 0; c < 16; c++) begin
            mid();
            if (bus.st_req_vld_o && bus.st_req_rdy_i) fires++;
            acc = bus.ruby_req_vld_i && bus.ruby_req_rdy_o;
            step();
            if (acc) begin
                id++;
                if (id > 10) idle();
                else drive(1'b0, 1'b0, 4'h0, ST_D, 8'(id), 56'h2000 + 56'(id), 64'(id));
            end
        end
        mid();
        check("t2_fires", 64'(fires), 8);
        check("t2_stvld", 64'(bus.st_req_vld_o), 0);
        check("t2_headid", 64'(bus.st_req_id_o), 9);
        check("t2_rdy", 64'(bus.ruby_req_rdy_o), 0);
        check("t2_cnt", 64'(cnt), 8);
        bus.st_resp_vld_i = 1'b1;
        step();
        bus.st_resp_vld_i = 1'b0;
        mid();
        check("t2_cnt7", 64'(cnt), 7);
        check("t2_stvld9", 64'(bus.st_req_vld_o), 1);
        check("t2_stid9", 64'(bus.st_req_id_o), 9);

        // ---- Fence behind two outstanding loads
        do_reset();
        bus.ld_req_rdy_i = 1'b1; bus.st_req_rdy_i = 1'b1;
        drive(1'b1, 1'b0, LD_D, 5'h0, 8'h05, 56'h3000, 64'h0);
        step();
        drive(1'b1, 1'b0, LD_D, 5'h0, 8'h06, 56'h3008, 64'h0);
        step();
        drive(1'b0, 1'b1, 4'h0, FENCE, 8'h20, 56'h0, 64'h0);
        mid();
        check("t3_rdy_fence", 64'(bus.ruby_req_rdy_o), 1);
        step();
        idle();
        mid();
        check("t3_cnt2", 64'(cnt), 2);
        check("t3_stvld_run", 64'(bus.st_req_vld_o), 0);
        check("t3_rdy_run", 64'(bus.ruby_req_rdy_o), 0);
        step();
        drive(1'b1, 1'b0, LD_D, 5'h0, 8'h07, 56'h3010, 64'h0);
        for (int k = 0; k < 3; k++) begin
            mid();
            check("t3_stvld_drain", 64'(bus.st_req_vld_o), 0);
            check("t3_rdy_drain", 64'(bus.ruby_req_rdy_o), 0);
            step();
        end
        bus.ld_resp_vld_i = 1'b1;
        step(); step();
        bus.ld_resp_vld_i = 1'b0;
        mid();
        check("t3_fence_vld", 64'(bus.st_req_vld_o), 1);
        check("t3_fence_id", 64'(bus.st_req_id_o), 64'h20);
        check("t3_fence_type", 64'(bus.st_req_type_o), 64'(FENCE));
        check("t3_fence_cnt", 64'(cnt), 0);
        check("t3_rdy_fence_iss", 64'(bus.ruby_req_rdy_o), 0);
        step();
        mid();
        check("t3_stvld_wait", 64'(bus.st_req_vld_o), 0);
        check("t3_cnt_wait", 64'(cnt), 1);
        check("t3_busy_wait", 64'(busy), 1);
        check("t3_rdy_wait", 64'(bus.ruby_req_rdy_o), 0);
        bus.st_resp_vld_i = 1'b1;
        step();
        bus.st_resp_vld_i = 1'b0;
        mid();
        check("t3_cnt_resp", 64'(cnt), 0);
        check("t3_rdy_exit", 64'(bus.ruby_req_rdy_o), 0);
        step();
        mid();
        check("t3_rdy_run2", 64'(bus.ruby_req_rdy_o), 1);
        step();
        idle();
        mid();
        check("t3_ld7_vld", 64'(bus.ld_req_vld_o), 1);
        check("t3_ld7_id", 64'(bus.ld_req_id_o), 7);

        // ---- AMO held by store-port back-pressure, then a load behind it
        do_reset();
        bus.ld_req_rdy_i = 1'b0; bus.st_req_rdy_i = 1'b0;
        drive(1'b0, 1'b1, 4'h0, AMOADDD, 8'h30, 56'hABC0, 64'hDEADBEEF01234567);
        step();
        drive(1'b1, 1'b0, LD_D, 5'h0, 8'h31, 56'h4000, 64'h0);
        mid();
        check("t4_rdy_ser", 64'(bus.ruby_req_rdy_o), 0);
        check("t4_stvld_run", 64'(bus.st_req_vld_o), 0);
        step();
        for (int k = 0; k < 5; k++) begin
            mid();
            check("t4_hold_vld", 64'(bus.st_req_vld_o), 1);
            check("t4_hold_id", 64'(bus.st_req_id_o), 64'h30);
            check("t4_hold_pa", 64'(bus.st_req_paddr_o), 64'hABC0);
            check("t4_hold_data", bus.st_req_data_o, 64'hDEADBEEF01234567);
            check("t4_hold_type", 64'(bus.st_req_type_o), 64'(AMOADDD));
            step();
        end
        bus.st_req_rdy_i = 1'b1;
        mid();
        check("t4_fire_vld", 64'(bus.st_req_vld_o), 1);
        step();
        bus.st_req_rdy_i = 1'b0;
        mid();
        check("t4_stvld_wait", 64'(bus.st_req_vld_o), 0);
        check("t4_rdy_wait", 64'(bus.ruby_req_rdy_o), 0);
        check("t4_cnt1", 64'(cnt), 1);
        bus.st_resp_vld_i = 1'b1;
        step();
        bus.st_resp_vld_i = 1'b0;
        mid();
        check("t4_rdy_exit", 64'(bus.ruby_req_rdy_o), 0);
        step();
        mid();
        check("t4_rdy_run", 64'(bus.ruby_req_rdy_o), 1);
        step();
        idle();
        mid();
        check("t4_ld_vld", 64'(bus.ld_req_vld_o), 1);
        check("t4_ld_id", 64'(bus.ld_req_id_o), 64'h31);

        // ---- Simultaneous fire and two responses, then underflow
        do_reset();
        bus.st_req_rdy_i = 1'b1;
        drive(1'b0, 1'b0, 4'h0, ST_D, 8'h40, 56'h5000, 64'h1);
        step();
        drive(1'b0, 1'b0, 4'h0, ST_D, 8'h41, 56'h5008, 64'h2);
        step();
        drive(1'b0, 1'b0, 4'h0, ST_D, 8'h42, 56'h5010, 64'h3);
        step();
        idle();
        mid();
        check("t5_cnt2", 64'(cnt), 2);
        check("t5_stvld", 64'(bus.st_req_vld_o), 1);
        bus.ld_resp_vld_i = 1'b1; bus.st_resp_vld_i = 1'b1;
        step();
        bus.ld_resp_vld_i = 1'b0; bus.st_resp_vld_i = 1'b0;
        mid();
        check("t5_cnt1", 64'(cnt), 1);
        check("t5_err0", 64'(err), 0);
        bus.st_resp_vld_i = 1'b1;
        step();
        bus.st_resp_vld_i = 1'b0;
        mid();
        check("t5_cnt0", 64'(cnt), 0);
        check("t5_err_still0", 64'(err), 0);
        bus.st_resp_vld_i = 1'b1;
        step();
        bus.st_resp_vld_i = 1'b0;
        mid();
        check("t5_cnt_sat", 64'(cnt), 0);
        check("t5_err1", 64'(err), 1);
        step();
        mid();
        check("t5_err_sticky", 64'(err), 1);

        // ---- Asynchronous reset in the middle of DRAIN
        bus.ld_req_rdy_i = 1'b1;
        drive(1'b1, 1'b0, LD_D, 5'h0, 8'h50, 56'h6000, 64'h0);
        step();
        drive(1'b1, 1'b0, LD_D, 5'h0, 8'h51, 56'h6008, 64'h0);
        step();
        drive(1'b1, 1'b0, LD_D, 5'h0, 8'h52, 56'h6010, 64'h0);
        step();
        drive(1'b0, 1'b1, 4'h0, FENCE, 8'h60, 56'h0, 64'h0);
        step();
        idle();
        step();
        mid();
        check("t6_cnt3", 64'(cnt), 3);
        check("t6_stvld_drain", 64'(bus.st_req_vld_o), 0);
        check("t6_busy", 64'(busy), 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_cnt_rst", 64'(cnt), 0);
        check("t6_err_rst", 64'(err), 0);
        check("t6_busy_rst", 64'(busy), 0);
        check("t6_ldvld_rst", 64'(bus.ld_req_vld_o), 0);
        check("t6_stvld_rst", 64'(bus.st_req_vld_o), 0);
        check("t6_rdy_rst", 64'(bus.ruby_req_rdy_o), 0);
        step();
        rst = 1'b0;
        mid();
        check("t6_rdy_run", 64'(bus.ruby_req_rdy_o), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
